// File: rtl/pe_dot_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pe_dot_sequencer_if                                                   |
// | Command, buffer-read and result signals of the dot-block sequencer.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface pe_dot_sequencer_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int CNT_WIDTH  = 12
);
   logic                  i_cmd_valid;
   logic                  o_cmd_ready;
   logic [ADDR_WIDTH-1:0] i_cmd_base_addr;
   logic [CNT_WIDTH-1:0]  i_cmd_num_blocks;
   logic                  i_stall;
   logic                  o_rd_en;
   logic [ADDR_WIDTH-1:0] o_rd_addr;
   logic                  o_dot_valid;
   logic                  o_result_valid;
   logic                  o_result_last;
   logic                  o_busy;
   logic                  o_done;

   modport slave (
      input  i_cmd_valid, i_cmd_base_addr, i_cmd_num_blocks, i_stall,
      output o_cmd_ready, o_rd_en, o_rd_addr, o_dot_valid,
             o_result_valid, o_result_last, o_busy, o_done
   );

   modport master (
      output i_cmd_valid, i_cmd_base_addr, i_cmd_num_blocks, i_stall,
      input  o_cmd_ready, o_rd_en, o_rd_addr, o_dot_valid,
             o_result_valid, o_result_last, o_busy, o_done
   );
endinterface
`default_nettype wire

// File: rtl/pe_dot_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pe_dot_sequencer                                                      |
// | Issues N contiguous buffer reads per command and tracks them through  |
// | the read and dot-array latencies to a single completion pulse.        |
// | Optional macro PE_DOT_SEQ_PERF_CNT_EN adds busy/stall perf counters.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module pe_dot_sequencer #(
   parameter int ADDR_WIDTH  = 10,
   parameter int CNT_WIDTH   = 12,
   parameter int RD_LATENCY  = 2,
   parameter int DOT_LATENCY = 5
) (
   input  wire logic          clock,
   input  wire logic          resetn,
   pe_dot_sequencer_if.slave  bus
`ifdef PE_DOT_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]        o_perf_busy_cycles,
   output logic [31:0]        o_perf_stall_cycles
`endif
);

   localparam int PIPE_LEN = RD_LATENCY + DOT_LATENCY;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic [CNT_WIDTH-1:0]  issued_q, issued_d;
   logic                  armed_q;
   logic [PIPE_LEN-1:0]   vld_q;
   logic [PIPE_LEN-1:0]   last_q;
   logic                  issue_en;
   logic                  issue_last;
   logic                  cmd_ready;

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      count_d    = count_q;
      issued_d   = issued_q;
      issue_en   = 1'b0;
      issue_last = 1'b0;
      cmd_ready  = 1'b0;
      case (state_q)
         IDLE: begin
            // armed_q keeps ready low until the first edge after reset release
            cmd_ready = armed_q;
            if (armed_q && bus.i_cmd_valid) begin
               base_d   = bus.i_cmd_base_addr;
               count_d  = bus.i_cmd_num_blocks;
               issued_d = '0;
               state_d  = (bus.i_cmd_num_blocks == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (!bus.i_stall) begin
               issue_en = 1'b1;
               issued_d = issued_q + CNT_ONE;
               if (issued_q == count_q - CNT_ONE) begin
                  issue_last = 1'b1;
                  state_d    = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (last_q[PIPE_LEN-1]) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         base_q   <= '0;
         count_q  <= '0;
         issued_q <= '0;
         armed_q  <= 1'b0;
         vld_q    <= '0;
         last_q   <= '0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         count_q  <= count_d;
         issued_q <= issued_d;
         armed_q  <= 1'b1;
         // Delay stages advance every cycle regardless of stall
         vld_q    <= {vld_q[PIPE_LEN-2:0], issue_en};
         last_q   <= {last_q[PIPE_LEN-2:0], issue_last};
      end
   end

   assign bus.o_cmd_ready    = cmd_ready;
   assign bus.o_rd_en        = issue_en;
   assign bus.o_rd_addr      = base_q + ADDR_WIDTH'(issued_q);
   assign bus.o_dot_valid    = vld_q[RD_LATENCY-1];
   assign bus.o_result_valid = vld_q[PIPE_LEN-1];
   assign bus.o_result_last  = last_q[PIPE_LEN-1];
   assign bus.o_busy         = (state_q != IDLE);
   assign bus.o_done         = (state_q == DONE);

`ifdef PE_DOT_SEQ_PERF_CNT_EN
   logic [31:0] perf_busy_q;
   logic [31:0] perf_stall_q;

   // Saturating, never cleared between commands
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         perf_busy_q  <= '0;
         perf_stall_q <= '0;
      end else begin
         if ((state_q != IDLE) && (perf_busy_q != '1)) begin
            perf_busy_q <= perf_busy_q + 32'd1;
         end
         if ((state_q == ISSUE) && bus.i_stall && (perf_stall_q != '1)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign o_perf_busy_cycles  = perf_busy_q;
   assign o_perf_stall_cycles = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pe_dot_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pe_dot_sequencer                                                   |
// | Scoreboard bench: a timeline model predicts every output event.       |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_pe_dot_sequencer;
   localparam int AW  = 10;
   localparam int CW  = 12;
   localparam int RD  = 2;
   localparam int DOT = 5;

   typedef struct {
      int          cyc;
      logic [AW-1:0] addr;
      bit          last;
   } ev_t;

   logic clock;
   logic resetn;
   pe_dot_sequencer_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus();
`ifdef PE_DOT_SEQ_PERF_CNT_EN
   logic [31:0] perf_busy;
   logic [31:0] perf_stall;
`endif

   pe_dot_sequencer #(
      .ADDR_WIDTH (AW),
      .CNT_WIDTH  (CW),
      .RD_LATENCY (RD),
      .DOT_LATENCY(DOT)
   ) dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus)
`ifdef PE_DOT_SEQ_PERF_CNT_EN
      ,
      .o_perf_busy_cycles (perf_busy),
      .o_perf_stall_cycles(perf_stall)
`endif
   );

   int cyc           = 0;
   int checks        = 0;
   int errors        = 0;
   int busy_lo       = 1;
   int busy_hi       = 0;
   int ready_ok_from = 1 << 30;
   int tot_busy      = 0;
   int tot_stall     = 0;
   ev_t rdq[$];
   ev_t resq[$];
   int  dotq[$];
   int  doneq[$];

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every output is compared each cycle against the predicted timeline
   always @(negedge clock) begin : mon
      ev_t t;
      bit  e;
      bit  b;
      b = (cyc >= busy_lo) && (cyc <= busy_hi);
      chk("busy", bus.o_busy, b);
      chk("cmd_ready", bus.o_cmd_ready, (cyc >= ready_ok_from) && !b);
      e = (rdq.size() > 0) && (rdq[0].cyc == cyc);
      chk("rd_en", bus.o_rd_en, e);
      if (e) begin
         t = rdq.pop_front();
         chk("rd_addr", bus.o_rd_addr, t.addr);
      end
      e = (dotq.size() > 0) && (dotq[0] == cyc);
      chk("dot_valid", bus.o_dot_valid, e);
      if (e) void'(dotq.pop_front());
      e = (resq.size() > 0) && (resq[0].cyc == cyc);
      chk("result_valid", bus.o_result_valid, e);
      if (e) begin
         t = resq.pop_front();
         chk("result_last", bus.o_result_last, t.last);
      end else begin
         chk("result_last_idle", bus.o_result_last, 0);
      end
      e = (doneq.size() > 0) && (doneq[0] == cyc);
      chk("done", bus.o_done, e);
      if (e) void'(doneq.pop_front());
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int k);
      repeat (k) step();
   endtask

   task automatic apply_reset();
      resetn              = 1'b0;
      bus.i_cmd_valid     = 1'b0;
      bus.i_stall         = 1'b0;
      rdq.delete();
      resq.delete();
      dotq.delete();
      doneq.delete();
      busy_lo       = 1;
      busy_hi       = 0;
      ready_ok_from = 1 << 30;
      tot_busy      = 0;
      tot_stall     = 0;
      #1;
      chk("rst_rd_en", bus.o_rd_en, 0);
      chk("rst_rd_addr", bus.o_rd_addr, 0);
      chk("rst_dot_valid", bus.o_dot_valid, 0);
      chk("rst_result_valid", bus.o_result_valid, 0);
      chk("rst_result_last", bus.o_result_last, 0);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_done", bus.o_done, 0);
      chk("rst_ready", bus.o_cmd_ready, 0);
      idle(2);
      chk("rst_ready_held", bus.o_cmd_ready, 0);
      resetn        = 1'b1;
      ready_ok_from = cyc + 1;
      step();
      chk("ready_after_release", bus.o_cmd_ready, 1);
   endtask

   // mode 0: no stall, 1: stall two cycles after the 2nd issue, 2: random stall and junk commands
   task automatic run_cmd(input logic [AW-1:0] base, input int n, input int mode, input int reset_at);
      int  a;
      int  c;
      int  i;
      int  j;
      int  done_c;
      int  st_add;
      bit  s;
      bit  stq[$];
      ev_t ev;
      a      = cyc;
      st_add = 0;
      chk("accept_ready", bus.o_cmd_ready, 1);
      bus.i_cmd_valid      = 1'b1;
      bus.i_cmd_base_addr  = base;
      bus.i_cmd_num_blocks = CW'(n);
      bus.i_stall          = 1'b0;
      // Issue timeline: reads start the cycle after accept, one per unstalled cycle
      c = a + 1;
      i = 0;
      j = 0;
      if (n == 0) begin
         done_c = a + 1;
      end else begin
         while (i < n) begin
            if (mode == 1)      s = (j == 2) || (j == 3);
            else if (mode == 2) s = ($urandom_range(3) == 0) && (j < 64);
            else                s = 1'b0;
            stq.push_back(s);
            if (!s) begin
               ev.cyc  = c;
               ev.addr = base + AW'(i);
               ev.last = (i == n - 1);
               rdq.push_back(ev);
               dotq.push_back(c + RD);
               ev.cyc = c + RD + DOT;
               resq.push_back(ev);
               i++;
            end else begin
               st_add++;
            end
            c++;
            j++;
         end
         done_c = (c - 1) + RD + DOT + 1;
      end
      doneq.push_back(done_c);
      busy_lo = a + 1;
      busy_hi = done_c;
      step();
      while (cyc <= done_c) begin
         if ((reset_at >= 0) && (cyc == a + reset_at)) begin
            apply_reset();
            return;
         end
         j = cyc - (a + 1);
         if (j < stq.size()) bus.i_stall = stq[j];
         else                bus.i_stall = (mode == 2) && ($urandom_range(1) == 1);
         if ((mode == 2) && ($urandom_range(2) == 0)) begin
            bus.i_cmd_valid      = 1'b1;
            bus.i_cmd_base_addr  = AW'($urandom);
            bus.i_cmd_num_blocks = CW'($urandom_range(9));
         end else begin
            bus.i_cmd_valid = 1'b0;
         end
         step();
      end
      bus.i_cmd_valid = 1'b0;
      bus.i_stall     = 1'b0;
      tot_busy  += done_c - a;
      tot_stall += st_add;
   endtask

   initial begin
      resetn               = 1'b0;
      bus.i_cmd_valid      = 1'b0;
      bus.i_cmd_base_addr  = '0;
      bus.i_cmd_num_blocks = '0;
      bus.i_stall          = 1'b0;
      #1;
      apply_reset();
      run_cmd(10'h155, 5, 1, -1);
`ifdef PE_DOT_SEQ_PERF_CNT_EN
      chk("perf_stall_req", perf_stall, 2);
      chk("perf_busy_req", perf_busy, 5 + 2 + 7 + 1);
`endif
      idle(2);
      run_cmd(10'h010, 4, 0, -1);
      run_cmd(10'h3FE, 3, 0, -1);
      idle(1);
      run_cmd(10'h000, 0, 0, -1);
      repeat (25) begin
         idle($urandom_range(2));
         run_cmd(AW'($urandom), $urandom_range(12), 2, -1);
      end
      run_cmd(10'h200, 8, 0, 12);
      idle(20);
      run_cmd(10'h100, 2, 0, -1);
      idle(3);
      chk("scoreboard_drained", rdq.size() + resq.size() + dotq.size() + doneq.size(), 0);
`ifdef PE_DOT_SEQ_PERF_CNT_EN
      chk("perf_busy_total", perf_busy, tot_busy);
      chk("perf_stall_total", perf_stall, tot_stall);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/pe_dot_sequencer.md
PE_DOT_SEQUENCER -- requirements
Module: pe_dot_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: width of the feature/filter buffer read address.
REQ-002 SHALL have parameter CNT_WIDTH, default 12: width of the block-count field.
REQ-003 SHALL have parameter RD_LATENCY, default 2: buffer read latency in cycles, legal range 1..8.
REQ-004 SHALL have parameter DOT_LATENCY, default 5: dot-array latency in cycles (DSP mult plus adder tree), legal range 1..16.
REQ-005 SHALL have port clock, input, 1 bit: the sole clock; all flops rise on it.
REQ-006 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port i_cmd_valid, input, 1 bit: command offered.
REQ-008 SHALL have port o_cmd_ready, output, 1 bit: command accepted when high together with i_cmd_valid.
REQ-009 SHALL have port i_cmd_base_addr, input, ADDR_WIDTH bits: first buffer address.
REQ-010 SHALL have port i_cmd_num_blocks, input, CNT_WIDTH bits: number of dot blocks to issue.
REQ-011 SHALL have port i_stall, input, 1 bit: downstream backpressure that inhibits issue.
REQ-012 SHALL have port o_rd_en, output, 1 bit: buffer read strobe.
REQ-013 SHALL have port o_rd_addr, output, ADDR_WIDTH bits: buffer read address.
REQ-014 SHALL have port o_dot_valid, output, 1 bit: operands presented to the dot array this cycle.
REQ-015 SHALL have port o_result_valid, output, 1 bit: dot result valid this cycle.
REQ-016 SHALL have port o_result_last, output, 1 bit: final result of the command.
REQ-017 SHALL have port o_busy, output, 1 bit: command in progress.
REQ-018 SHALL have port o_done, output, 1 bit: one-cycle completion pulse.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, DRAIN and DONE.
REQ-020 o_cmd_ready SHALL be 1 only in IDLE; a handshake SHALL latch addr and count, then move to ISSUE, or to DONE if count==0.
REQ-021 In ISSUE with i_stall=0, o_rd_en SHALL be 1, o_rd_addr SHALL be base+issued, and the issued counter SHALL increment.
REQ-022 In ISSUE with i_stall=1, o_rd_en SHALL be 0 and the address SHALL hold.
REQ-023 Address SHALL wrap modulo 2^ADDR_WIDTH.
REQ-024 After the final issue (issued==count-1 with no stall), the FSM SHALL go to DRAIN.
REQ-025 o_dot_valid SHALL equal o_rd_en delayed RD_LATENCY cycles.
REQ-026 o_result_valid SHALL equal o_dot_valid delayed DOT_LATENCY cycles.
REQ-027 A last flag SHALL be set on the final issue and travel with the valid through the same delay stages, appearing as o_result_last.
REQ-028 DRAIN SHALL exit to DONE in the cycle o_result_last is 1.
REQ-029 DONE SHALL last exactly one cycle with o_done=1, then return to IDLE.
REQ-030 o_busy SHALL be 1 in ISSUE, DRAIN and DONE.
REQ-031 i_stall SHALL NOT affect in-flight delay stages; those always advance.
REQ-032 Commands presented while not in IDLE SHALL NOT be accepted.
REQ-033 For a stall-free command of N blocks, o_done SHALL occur exactly RD_LATENCY+DOT_LATENCY+N+1 cycles after the accept edge.

Reset
REQ-034 resetn=0 SHALL asynchronously force state IDLE, clear all counters and delay stages, and drive every output to 0 except o_cmd_ready, which SHALL be 0 during reset and 1 from the first edge after release.
REQ-035 Reset mid-command SHALL discard all in-flight valids; no o_result_valid or o_done SHALL follow release.

Configuration
REQ-036 When macro PE_DOT_SEQ_PERF_CNT_EN is defined, outputs o_perf_busy_cycles (32 bits; counts cycles with o_busy=1) and o_perf_stall_cycles (32 bits; counts ISSUE cycles with i_stall=1) SHALL exist, saturate at max, clear on reset, and not clear between commands.
REQ-037 Without PE_DOT_SEQ_PERF_CNT_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-038 Default params, cmd base=0x010, N=4, no stall -> rd_addr 0x010..0x013 on 4 consecutive cycles; result_valid 4 cycles starting 7 after first rd_en; last on the 4th; done 1 cycle later.
REQ-039 base=0x3FE, N=3 -> rd_addr 0x3FE, 0x3FF, 0x000.
REQ-040 N=5 with i_stall high for 2 cycles after the 2nd issue -> exactly 5 rd_en, addresses contiguous, result gap of 2 cycles, single last.
REQ-041 N=0 -> ready drops, done pulses in the cycle after accept, no rd_en or result_valid.
REQ-042 resetn asserted during DRAIN of N=8 -> outputs 0 immediately; after release no result_valid and ready=1.
REQ-043 With PE_DOT_SEQ_PERF_CNT_EN, the REQ-040 run -> stall count 2 and busy count = 5+2+7+1.
